mem_ctrl_nport: RTL and testbench
=================================

MEM_CTRL_NPORT -- requirements
Module: mem_ctrl_nport

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, RAM-unit address width.
REQ-002 SHALL have parameter RAM_W, default 16, RAM data width.
REQ-003 SHALL have parameter RATIO, default 2, RAM beats per word (power of 2, >=1); WORD_W = RAM_W*RATIO.
REQ-004 SHALL have parameter PORTS, default 2, number of requestor ports (port 0 = fetch, port 1 = memory stage).
REQ-005 SHALL have parameter ARB_MODE, default 1, arbitration mode: 0 fixed priority, 1 round-robin.
REQ-006 clock  in  1  single clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  PORTS  per-port request.
REQ-009 req_ready  out  PORTS  per-port accept; a request transfers when req_valid[p] and req_ready[p] are both high.
REQ-010 req_we  in  PORTS  1 write, 0 read.
REQ-011 req_addr  in  PORTS*ADDR_W  RAM-unit address, port p at [p*ADDR_W +: ADDR_W].
REQ-012 req_wdata  in  PORTS*WORD_W  write word per port.
REQ-013 rsp_valid  out  PORTS  one-cycle completion pulse (read data or write ack).
REQ-014 rsp_data  out  WORD_W  read word, valid when any rsp_valid bit is high.
REQ-015 ram_addr  out  ADDR_W  RAM address.
REQ-016 ram_we  out  1  RAM write enable.
REQ-017 ram_wdata  out  RAM_W  RAM write data.
REQ-018 ram_rdata  in  RAM_W  RAM read data, valid the cycle after ram_addr is presented.

Function
REQ-019 SHALL use FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-020 IDLE: at most one req_ready bit high, only for the granted port and only when that port has req_valid high; all other states drive req_ready = 0.
REQ-021 On a transfer, SHALL latch port, we, addr, wdata, set beat = 0, and go to ACCESS.
REQ-022 ACCESS: ram_addr = {addr[ADDR_W-1:log2 RATIO], beat}; low log2(RATIO) request address bits are ignored.
REQ-023 Beat b carries word bits [b*RAM_W +: RAM_W], so beat 0 is the least significant lane.
REQ-024 ACCESS: ram_we = latched we; ram_wdata = lane[beat]; beat increments each cycle.
REQ-025 ACCESS: go to CAPTURE after beat RATIO-1.
REQ-026 Read: ram_rdata sampled one cycle after each beat's address goes into lane[b]; the last lane is sampled in CAPTURE.
REQ-027 ram_we SHALL be 0 in every state except ACCESS of a write.
REQ-028 RESP: rsp_valid[port] = 1 for exactly one cycle, rsp_data = assembled word (don't-care for writes); then go to IDLE.
REQ-029 Latency: transfer at cycle 0, beats in cycles 1..RATIO, CAPTURE at RATIO+1, RESP at RATIO+2; the next transfer is possible at RATIO+3.
REQ-030 ARB_MODE 0: lowest-index valid port wins.
REQ-031 ARB_MODE 1: the first valid port after last_grant (cyclic) wins; last_grant updates only on a transfer.
REQ-032 A port deasserting req_valid in IDLE before transfer SHALL cause no access.
REQ-033 Requests arriving outside IDLE SHALL be held by the requestor and are not lost or reordered.
REQ-034 rsp_data SHALL hold its last value outside RESP.

Reset
REQ-035 reset low SHALL immediately force IDLE, req_ready = 0, rsp_valid = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0, rsp_data = 0, beat = 0, last_grant = PORTS-1.
REQ-036 Reset mid-ACCESS SHALL abort the access with no rsp_valid; the partially written word is undefined.
REQ-037 The first cycle after reset release is IDLE, with port 0 winning first in both modes.

Structure
REQ-038 Package mem_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-039 Arbitration SHALL be a sub-module rr_arbiter (PORTS, ARB_MODE; inputs req, last_grant; output one-hot grant).

Verification
REQ-040 Write port1 addr 0x00010, data 0xDEADBEEF -> cycle 1 ram_addr 0x00010 we=1 wdata 0xBEEF; cycle 2 0x00011 0xDEAD; rsp_valid[1] in cycle 4.
REQ-041 Read port0 addr 0x00010 after REQ-040 -> rsp_valid[0] in cycle 4, rsp_data 0xDEADBEEF, ram_we stays 0.
REQ-042 ARB_MODE 1, both ports valid continuously -> grants alternate 0,1,0,1, one transfer every 5 cycles.
REQ-043 ARB_MODE 0, both ports valid continuously -> port 0 always granted, port 1 starved.
REQ-044 Assert reset during write beat 1 -> ram_we low immediately, no rsp_valid; after release a read of port0 completes in 4 cycles.
REQ-045 Read with addr 0x00013 -> RAM accesses at 0x00012 and 0x00013; rsp_data = {mem[0x00013], mem[0x00012]}.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared FSM state type, default parameter values and width helper for the
// N-port memory controller.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_RAM_W    = 16;
  localparam int DEF_RATIO    = 2;
  localparam int DEF_PORTS    = 2;
  localparam int DEF_ARB_MODE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Port arbiter: fixed priority (lowest index wins) or round-robin starting
// after the last granted port. Output grant is one-hot, or zero when no
// port requests.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int PORTS    = DEF_PORTS,
  parameter int ARB_MODE = DEF_ARB_MODE,
  localparam int PW      = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [PW-1:0]    last_grant_i,
  output logic [PORTS-1:0] grant_o
);

  logic found_s;

  // Scan candidates in priority order and grant the first requesting port.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < PORTS; i++) begin
        if (!found_s && req_i[i]) begin
          grant_o[i] = 1'b1;
          found_s    = 1'b1;
        end else begin
          grant_o[i] = grant_o[i];
        end
      end
    end else begin
      // Offset 1 is the port right after last_grant; offset PORTS wraps back
      // to last_grant itself so a lone requester is always served.
      for (int i = 1; i <= PORTS; i++) begin
        for (int j = 0; j < PORTS; j++) begin
          if (!found_s && req_i[j] && (j == ((int'(last_grant_i) + i) % PORTS))) begin
            grant_o[j] = 1'b1;
            found_s    = 1'b1;
          end else begin
            grant_o[j] = grant_o[j];
          end
        end
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_nport.sv
// Multi-port controller in front of a narrow synchronous RAM. One request at
// a time is accepted from an arbitrated port; its word is moved as RATIO
// RAM beats (least significant lane first) and completed by a one-cycle
// rsp_valid pulse on the requesting port.
module mem_ctrl_nport
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RAM_W    = DEF_RAM_W,
  parameter int RATIO    = DEF_RATIO,
  parameter int PORTS    = DEF_PORTS,
  parameter int ARB_MODE = DEF_ARB_MODE,
  localparam int WORD_W  = RAM_W * RATIO,
  localparam int PW      = idx_w(PORTS),
  localparam int BW      = idx_w(RATIO)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORTS-1:0]         req_valid_i,
  output logic [PORTS-1:0]         req_ready_o,
  input  logic [PORTS-1:0]         req_we_i,
  input  logic [PORTS*ADDR_W-1:0]  req_addr_i,
  input  logic [PORTS*WORD_W-1:0]  req_wdata_i,
  output logic [PORTS-1:0]         rsp_valid_o,
  output logic [WORD_W-1:0]        rsp_data_o,
  output logic [ADDR_W-1:0]        ram_addr_o,
  output logic                     ram_we_o,
  output logic [RAM_W-1:0]         ram_wdata_o,
  input  logic [RAM_W-1:0]         ram_rdata_i
);

  // Request address bits below the beat index are ignored; the beat counter
  // replaces them on the RAM address.
  localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'(RATIO - 1);
  localparam logic [BW-1:0]     LAST_BEAT = BW'(RATIO - 1);

  state_e              state_q,      state_d;
  logic [PW-1:0]       port_q,       port_d;
  logic                we_q,         we_d;
  logic [ADDR_W-1:0]   addr_q,       addr_d;
  logic [WORD_W-1:0]   wdata_q,      wdata_d;
  logic [BW-1:0]       beat_q,       beat_d;
  logic [WORD_W-1:0]   lane_q,       lane_d;
  logic [PW-1:0]       last_grant_q, last_grant_d;
  logic [WORD_W-1:0]   rsp_data_q,   rsp_data_d;
  logic [PORTS-1:0]    rsp_valid_q,  rsp_valid_d;
  logic [ADDR_W-1:0]   ram_addr_q,   ram_addr_d;
  logic                ram_we_q,     ram_we_d;
  logic [RAM_W-1:0]    ram_wdata_q,  ram_wdata_d;

  logic [PORTS-1:0]    grant_s;
  logic [PW-1:0]       gnt_idx_s;
  logic                idle_s;
  logic                transfer_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [WORD_W-1:0]   sel_wdata_s;
  logic [BW-1:0]       beat_nx_s;

  rr_arbiter #(
    .PORTS    (PORTS),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req_i        (req_valid_i),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s)
  );

  // Ready is only offered in IDLE and never while reset is held, so nothing
  // can transfer during reset even though the state register reads IDLE.
  assign idle_s      = (state_q == IDLE) && rst_ni;
  assign req_ready_o = idle_s ? grant_s : '0;
  assign transfer_s  = idle_s && (|grant_s);
  assign beat_nx_s   = beat_q + BW'(1);

  // Encode the one-hot grant and mux the granted port's request fields.
  always_comb begin
    gnt_idx_s   = '0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int j = 0; j < PORTS; j++) begin
      gnt_idx_s   = gnt_idx_s   | (grant_s[j] ? PW'(j) : PW'(0));
      sel_we_s    = sel_we_s    | (grant_s[j] & req_we_i[j]);
      sel_addr_s  = sel_addr_s  | (req_addr_i[j*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[j]}});
      sel_wdata_s = sel_wdata_s | (req_wdata_i[j*WORD_W +: WORD_W] & {WORD_W{grant_s[j]}});
    end
  end

  // Next-state and next-output logic; RAM outputs are computed one cycle
  // ahead so each beat appears on registered ports while in ACCESS.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = '0;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    case (state_q)
      IDLE: begin
        if (transfer_s) begin
          state_d      = ACCESS;
          port_d       = gnt_idx_s;
          we_d         = sel_we_s;
          addr_d       = sel_addr_s;
          wdata_d      = sel_wdata_s;
          beat_d       = BW'(0);
          last_grant_d = gnt_idx_s;
          ram_addr_d   = sel_addr_s & ~LOW_MASK;
          ram_we_d     = sel_we_s;
          ram_wdata_d  = sel_wdata_s[RAM_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Read data of the previous beat arrives now.
        if (beat_q != BW'(0)) begin
          lane_d[int'(beat_q - BW'(1)) * RAM_W +: RAM_W] = ram_rdata_i;
        end else begin
          lane_d = lane_q;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = CAPTURE;
        end else begin
          beat_d      = beat_nx_s;
          ram_addr_d  = (addr_q & ~LOW_MASK) | ADDR_W'(beat_nx_s);
          ram_we_d    = we_q;
          ram_wdata_d = wdata_q[int'(beat_nx_s) * RAM_W +: RAM_W];
        end
      end
      CAPTURE: begin
        lane_d[(RATIO-1)*RAM_W +: RAM_W] = ram_rdata_i;
        beat_d  = BW'(0);
        state_d = RESP;
        for (int j = 0; j < PORTS; j++) begin
          rsp_valid_d[j] = (port_q == PW'(j));
        end
        if (!we_q) begin
          rsp_data_d = lane_d;
        end else begin
          rsp_data_d = rsp_data_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      port_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      beat_q       <= '0;
      lane_q       <= '0;
      last_grant_q <= PW'(PORTS - 1);
      rsp_data_q   <= '0;
      rsp_valid_q  <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      beat_q       <= beat_d;
      lane_q       <= lane_d;
      last_grant_q <= last_grant_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_we_o    = ram_we_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_mem_ctrl_nport.sv
// Bench for mem_ctrl_nport: a round-robin instance driven by directed and
// random requests and checked against a word-level memory model, plus a
// fixed-priority instance checked for starvation of port 1.
module tb_mem_ctrl_nport;

  localparam int AW = 18;
  localparam int RW = 16;
  localparam int R  = 2;
  localparam int P  = 2;
  localparam int WW = RW * R;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic [P-1:0]    req_valid = '0;
  logic [P-1:0]    req_ready;
  logic [P-1:0]    req_we = '0;
  logic [P*AW-1:0] req_addr = '0;
  logic [P*WW-1:0] req_wdata = '0;
  logic [P-1:0]    rsp_valid;
  logic [WW-1:0]   rsp_data;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [RW-1:0]   ram_wdata;
  logic [RW-1:0]   ram_rdata = '0;

  // Fixed-priority instance signals
  logic [P-1:0]    fp_valid = '0;
  logic [P-1:0]    fp_ready;
  logic [P-1:0]    fp_we = '0;
  logic [P*AW-1:0] fp_addr = {18'h00004, 18'h00000};
  logic [P*WW-1:0] fp_wdata = '0;
  logic [P-1:0]    fp_rsp_valid;
  logic [WW-1:0]   fp_rsp_data;
  logic [AW-1:0]   fp_ram_addr;
  logic            fp_ram_we;
  logic [RW-1:0]   fp_ram_wdata;
  logic [RW-1:0]   fp_ram_rdata = '0;

  mem_ctrl_nport #(.ADDR_W(AW), .RAM_W(RW), .RATIO(R), .PORTS(P), .ARB_MODE(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  mem_ctrl_nport #(.ADDR_W(AW), .RAM_W(RW), .RATIO(R), .PORTS(P), .ARB_MODE(0)) dut_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(fp_valid), .req_ready_o(fp_ready), .req_we_i(fp_we),
    .req_addr_i(fp_addr), .req_wdata_i(fp_wdata),
    .rsp_valid_o(fp_rsp_valid), .rsp_data_o(fp_rsp_data),
    .ram_addr_o(fp_ram_addr), .ram_we_o(fp_ram_we), .ram_wdata_o(fp_ram_wdata),
    .ram_rdata_i(fp_ram_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM: write on the edge, read data valid the next cycle.
  bit [RW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: word memory, controller availability, arbitration.
  typedef struct { int port; bit we; logic [WW-1:0] data; int cyc; } exp_t;
  typedef struct { int port; int cyc; } tr_t;
  exp_t exp_q[$];
  tr_t  tlog[$];
  bit [WW-1:0] ref_mem [0:(1<<(AW-1))-1];
  int          last_g = P - 1;
  int          next_free = 0;
  bit          act_valid = 1'b0;
  int          act_t = 0;
  logic [AW-1:0] act_addr = '0;
  bit          act_we = 1'b0;
  logic [WW-1:0] act_wdata = '0;
  logic [P-1:0] acc_s = '0;
  logic [P-1:0] exp_rdy;
  int          b;
  exp_t        e;

  // Monitor/scoreboard for the round-robin instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_rsp_data", rsp_data, 0);
      exp_q.delete();
      acc_s     = '0;
      last_g    = P - 1;
      next_free = 0;
      act_valid = 1'b0;
    end else begin
      exp_rdy = '0;
      if (cyc >= next_free) begin
        for (int i = 1; i <= P; i++) begin
          if (exp_rdy == '0 && req_valid[(last_g + i) % P]) exp_rdy[(last_g + i) % P] = 1'b1;
        end
      end
      chk("req_ready", req_ready, exp_rdy);

      if (act_valid && cyc >= act_t + 1 && cyc <= act_t + R) begin
        b = cyc - act_t - 1;
        chk("ram_addr", ram_addr, (int'(act_addr) / R) * R + b);
        chk("ram_we", ram_we, act_we);
        if (act_we) chk("ram_wdata", ram_wdata, (act_wdata >> (RW * b)) & 32'h0000FFFF);
      end else begin
        chk("ram_we_idle", ram_we, 0);
      end

      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_port", rsp_valid, 2'b01 << e.port);
          chk("rsp_latency", cyc - e.cyc, R + 2);
          if (!e.we) chk("rsp_data", rsp_data, e.data);
        end
      end

      acc_s = req_valid & req_ready;
      for (int p = 0; p < P; p++) begin
        if (acc_s[p]) begin
          e.port = p;
          e.we   = req_we[p];
          e.cyc  = cyc;
          if (req_we[p]) begin
            ref_mem[int'(req_addr[p*AW +: AW]) / R] = req_wdata[p*WW +: WW];
            e.data = req_wdata[p*WW +: WW];
          end else begin
            e.data = ref_mem[int'(req_addr[p*AW +: AW]) / R];
          end
          exp_q.push_back(e);
          tlog.push_back('{port: p, cyc: cyc});
          last_g    = p;
          next_free = cyc + R + 3;
          act_valid = 1'b1;
          act_t     = cyc;
          act_addr  = req_addr[p*AW +: AW];
          act_we    = req_we[p];
          act_wdata = req_wdata[p*WW +: WW];
        end
      end
    end
  end

  // Transfer tracking for the fixed-priority instance.
  int fp_cnt0 = 0;
  int fp_cnt1 = 0;
  int fp_prev = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      fp_prev = -1;
    end else begin
      if (fp_valid[1] && fp_ready[1]) fp_cnt1++;
      if (fp_valid[0] && fp_ready[0]) begin
        fp_cnt0++;
        if (fp_prev >= 0) chk("fp_spacing", cyc - fp_prev, R + 3);
        fp_prev = cyc;
      end
    end
  end

  task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [WW-1:0] d);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*WW +: WW] = d;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk);
      if (acc_s[p]) done = 1'b1;
    end
    #1 req_valid[p] = 1'b0;
    chk("issue_accepted", done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int log_start;

  initial begin
    // Reset with requests pending: nothing may be offered ready.
    req_valid = 2'b11;
    fp_valid  = 2'b11;
    repeat (3) @(negedge clk);
    req_valid = '0;
    fp_valid  = '0;
    #1 rst_n = 1'b1;

    // Word write, then read back, on different ports.
    issue(1, 1'b1, 18'h00010, 32'hDEADBEEF);
    repeat (5) @(posedge clk);
    issue(0, 1'b0, 18'h00010, 32'h0);
    repeat (5) @(posedge clk);

    // Unaligned read address: low bit ignored, lanes from 0x12 and 0x13.
    issue(0, 1'b1, 18'h00012, 32'hCAFEF00D);
    repeat (5) @(posedge clk);
    issue(0, 1'b0, 18'h00013, 32'h0);
    repeat (5) @(posedge clk);

    // Reset during the second write beat aborts the access.
    issue(0, 1'b1, 18'h00100, 32'h12345678);
    @(posedge clk); #2;
    chk("abort_pre_we", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_addr", ram_addr, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    issue(0, 1'b0, 18'h00010, 32'h0);
    repeat (5) @(posedge clk);

    // Both ports requesting continuously on both instances.
    log_start = tlog.size();
    @(posedge clk); #1;
    req_we = '0;
    req_addr[0 +: AW]  = 18'h00020;
    req_addr[AW +: AW] = 18'h00022;
    req_valid = 2'b11;
    fp_valid  = 2'b11;
    repeat (22) @(posedge clk);
    #1;
    req_valid = '0;
    fp_valid  = '0;
    repeat (8) @(posedge clk);
    chk("rr_count_ge4", (tlog.size() - log_start) >= 4, 1);
    if (tlog.size() - log_start >= 4) begin
      // Port 0 held the previous grant, so port 1 goes first.
      for (int i = 0; i < 4; i++) begin
        chk("rr_port", tlog[log_start + i].port, (i % 2 == 0) ? 1 : 0);
        if (i > 0) chk("rr_spacing", tlog[log_start + i].cyc - tlog[log_start + i - 1].cyc, R + 3);
      end
    end
    chk("fp_port0_ge4", fp_cnt0 >= 4, 1);
    chk("fp_port1_starved", fp_cnt1, 0);

    // Random traffic with occasional withdrawn requests.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      for (int p = 0; p < P; p++) begin
        if (req_valid[p]) begin
          if (acc_s[p]) req_valid[p] = 1'b0;
          else if ($urandom_range(0, 15) == 0) req_valid[p] = 1'b0;
        end
        if (!req_valid[p] && $urandom_range(0, 1) == 1) begin
          req_valid[p] = 1'b1;
          req_we[p] = $urandom_range(0, 1) == 1;
          req_addr[p*AW +: AW] = 18'(32'h20 + $urandom_range(0, 63));
          req_wdata[p*WW +: WW] = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
